// File: rtl/instr_fetch_pkg.sv
// Shared FSM state type and constants for the RISC-V instruction fetch stage.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DRAIN
    } if_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; with neither load nor
// hold the slot empties so decode never sees the same instruction twice.
module if_id_reg
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    output logic [31:0] instr_q,
    output logic [31:0] pc_q,
    output logic        valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end else if (!hold) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, single-outstanding imem handshake, IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt_o / stall_cnt_o performance counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] pc_o,
    output logic        valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    if_state_e   state, state_n;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        ld_resp, ld_skid, cap_skid;
    logic        take;
    logic        load;

    // Redirect suppresses any request so no stale transaction is left in flight.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        ld_resp  = 1'b0;
        ld_skid  = 1'b0;
        cap_skid = 1'b0;
        if (redirect_i) begin
            state_n = ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid) ? S_DRAIN : S_REQ;
        end else begin
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ: begin
                    imem_req = 1'b1;
                    if (imem_gnt) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall_i) begin
                            cap_skid = 1'b1;
                            state_n  = S_FULL;
                        end else begin
                            ld_resp  = 1'b1;
                            imem_req = 1'b1;
                            state_n  = imem_gnt ? S_WAIT : S_REQ;
                        end
                    end
                end
                S_FULL: begin
                    if (!stall_i) begin
                        ld_skid = 1'b1;
                        state_n = S_REQ;
                    end
                end
                S_DRAIN: if (imem_rvalid) state_n = S_REQ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign imem_addr = fetch_pc;
    assign take      = imem_req && imem_gnt;
    assign load      = ld_resp || ld_skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_n;
            if (redirect_i) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (take) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Skid contents are only meaningful in S_FULL; leaving that state invalidates them.
    always_ff @(posedge clk) begin
        if (take) inflight_pc <= fetch_pc;
        if (cap_skid) begin
            skid_instr <= imem_rdata;
            skid_pc    <= inflight_pc;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (redirect_i),
        .hold    (stall_i),
        .instr_d (ld_skid ? skid_instr : imem_rdata),
        .pc_d    (ld_skid ? skid_pc : inflight_pc),
        .instr_q (Instruction),
        .pc_q    (pc_o),
        .valid_q (valid_o)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (load) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (stall_i && valid_o && !redirect_i) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized memory/stall/redirect traffic.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] Instruction;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // memory model: at most one pending response, data = address | 1
    bit          pend = 1'b0;
    int          pend_lat = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_i     (stall_i),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .Instruction (Instruction),
        .pc_o        (pc_o),
        .valid_o     (valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // One clock cycle of memory activity; entered and left at posedge+1.
    task automatic mem_cycle(input bit g, input int lat, output bit req, output bit hs,
                             output bit viol, output logic [31:0] addr);
        bit had;
        if (pend && pend_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr | 32'h1;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_lat--;
        end
        had      = pend;
        imem_gnt = g;
        #1;
        req  = imem_req;
        addr = imem_addr;
        hs   = req && g;
        viol = hs && had;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_lat  = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", Instruction, NOP); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    endtask

    task automatic test_stream();
        bit req, hs, viol; logic [31:0] a;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            mem_cycle(1'b1, 0, req, hs, viol, a);
            checks++;
            if (valid_o !== 1'(i >= 3)) begin
                errors++; $display("FAIL stream_valid cyc %0d: got %b expected %b", i, valid_o, (i >= 3));
            end
            if (i >= 3) begin
                checks++;
                if (pc_o !== 32'(4 * (i - 3)) || Instruction !== (32'(4 * (i - 3)) | 32'h1)) begin
                    errors++; $display("FAIL stream_pc cyc %0d: got pc %h instr %h expected pc %h", i, pc_o, Instruction, 32'(4 * (i - 3)));
                end
            end
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (fetch_cnt_o !== 32'd8) begin errors++; $display("FAIL stream_fetch_cnt: got %0d expected 8", fetch_cnt_o); end
`endif
    endtask

    task automatic test_stall();
        bit req, hs, viol; logic [31:0] a, exp;
        do_reset();
        repeat (3) mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL stall_pre: got valid %b pc %h expected 1 0", valid_o, pc_o); end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_cycle(1'b1, 0, req, hs, viol, a);
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_req cyc %0d: got %b expected 0", k, req); end
            checks++;
            if (pc_o !== 32'h0 || Instruction !== 32'h1 || valid_o !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc %0d: got pc %h instr %h valid %b expected 0 1 1", k, pc_o, Instruction, valid_o);
            end
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (stall_cnt_o !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt_o); end
`endif
        stall_i = 1'b0;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b expected 0", req); end
        checks++;
        if (pc_o !== 32'h4 || Instruction !== 32'h5 || valid_o !== 1'b1) begin
            errors++; $display("FAIL stall_skid: got pc %h instr %h valid %b expected 4 5 1", pc_o, Instruction, valid_o);
        end
        exp = 32'h8;
        for (int k = 0; k < 6; k++) begin
            mem_cycle(1'b1, 0, req, hs, viol, a);
            if (valid_o === 1'b1) begin
                checks++; if (pc_o !== exp) begin errors++; $display("FAIL stall_after: got pc %h expected %h", pc_o, exp); end
                exp += 32'h4;
            end
        end
        checks++; if (exp !== 32'h1C) begin errors++; $display("FAIL stall_count: got next pc %h expected 1c", exp); end
    endtask

    task automatic test_redirect_wait();
        bit req, hs, viol; logic [31:0] a;
        do_reset();
        mem_cycle(1'b1, 0, req, hs, viol, a);
        mem_cycle(1'b1, 0, req, hs, viol, a);
        mem_cycle(1'b1, 2, req, hs, viol, a);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL rdw_pre: got valid %b pc %h expected 1 0", valid_o, pc_o); end
        redirect_i = 1'b1; redirect_pc = 32'h0000_0100;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        redirect_i = 1'b0;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rdw_req_r: got %b expected 0", req); end
        checks++; if (valid_o !== 1'b0 || Instruction !== NOP) begin errors++; $display("FAIL rdw_flush: got valid %b instr %h expected 0 %h", valid_o, Instruction, NOP); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rdw_drain_req: got %b expected 0", req); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (req !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL rdw_discard: got req %b valid %b expected 0 0", req, valid_o); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (hs !== 1'b1 || a !== 32'h100) begin errors++; $display("FAIL rdw_new_addr: got req %b addr %h expected 1 100", hs, a); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || Instruction !== 32'h101) begin
            errors++; $display("FAIL rdw_first: got valid %b pc %h instr %h expected 1 100 101", valid_o, pc_o, Instruction);
        end
    endtask

    task automatic test_redirect_combo();
        bit req, hs, viol; logic [31:0] a;
        do_reset();
        repeat (3) mem_cycle(1'b1, 0, req, hs, viol, a);
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc = 32'h0000_0200;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        stall_i = 1'b0; redirect_i = 1'b0;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL combo_req: got %b expected 0", req); end
        checks++; if (valid_o !== 1'b0 || Instruction !== NOP) begin errors++; $display("FAIL combo_flush: got valid %b instr %h expected 0 %h", valid_o, Instruction, NOP); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (hs !== 1'b1 || a !== 32'h200) begin errors++; $display("FAIL combo_addr: got req %b addr %h expected 1 200", hs, a); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h200 || Instruction !== 32'h201) begin
            errors++; $display("FAIL combo_first: got valid %b pc %h instr %h expected 1 200 201", valid_o, pc_o, Instruction);
        end
    endtask

    task automatic test_wrap();
        bit req, hs, viol; logic [31:0] a;
        do_reset();
        redirect_i = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        redirect_i = 1'b0;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (hs !== 1'b1 || a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got req %b addr %h expected 1 fffffffc", hs, a); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (hs !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req %b addr %h expected 1 0", hs, a); end
        checks++; if (pc_o !== 32'hFFFF_FFFC || Instruction !== 32'hFFFF_FFFD) begin errors++; $display("FAIL wrap_pc_top: got pc %h instr %h", pc_o, Instruction); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc_zero: got valid %b pc %h expected 1 0", valid_o, pc_o); end
    endtask

    task automatic test_reset_mid();
        bit req, hs, viol; logic [31:0] a;
        do_reset();
        repeat (3) mem_cycle(1'b1, 0, req, hs, viol, a);
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || Instruction !== NOP || pc_o !== 32'h0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL midrst_values: got req %b addr %h instr %h pc %h valid %b", imem_req, imem_addr, Instruction, pc_o, valid_o);
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (fetch_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin errors++; $display("FAIL midrst_cnt: got %0d %0d expected 0 0", fetch_cnt_o, stall_cnt_o); end
`endif
        pend = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend = 1'b1; pend_lat = 0; pend_addr = 32'h40;
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (req !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL midrst_stray: got req %b valid %b expected 0 0", req, valid_o); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++; if (hs !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL midrst_first_addr: got req %b addr %h expected 1 0", hs, a); end
        mem_cycle(1'b1, 0, req, hs, viol, a);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || Instruction !== 32'h1) begin
            errors++; $display("FAIL midrst_first: got valid %b pc %h instr %h expected 1 0 1", valid_o, pc_o, Instruction);
        end
    endtask

    // Reference: granted addresses run +4 from the last redirect target; delivered
    // instructions run +4 likewise, stall freezes IF/ID, redirect empties it.
    task automatic test_random();
        bit req, hs, viol, st, rd;
        logic [31:0] a, rpc, exp_fetch, exp_pc, p_instr, p_pc;
        logic p_valid;
        int delivered;
        do_reset();
        exp_fetch = 32'h0; exp_pc = 32'h0; p_instr = NOP; p_pc = 32'h0; p_valid = 1'b0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(99) < 25);
            rd  = ($urandom_range(99) < 4);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            stall_i = st; redirect_i = rd; redirect_pc = rpc;
            mem_cycle(($urandom_range(99) < 70), $urandom_range(3), req, hs, viol, a);
            if (hs) begin
                checks++; if (viol) begin errors++; $display("FAIL rnd_outstanding cyc %0d: got second request %h expected none", c, a); end
                checks++; if (a !== exp_fetch) begin errors++; $display("FAIL rnd_fetch_addr cyc %0d: got %h expected %h", c, a, exp_fetch); end
                exp_fetch = a + 32'h4;
            end
            if (rd) begin
                exp_fetch = rpc & 32'hFFFF_FFFC;
                exp_pc    = rpc & 32'hFFFF_FFFC;
                checks++;
                if (valid_o !== 1'b0 || Instruction !== NOP) begin
                    errors++; $display("FAIL rnd_flush cyc %0d: got valid %b instr %h expected 0 %h", c, valid_o, Instruction, NOP);
                end
            end else if (st) begin
                checks++;
                if ({Instruction, pc_o, valid_o} !== {p_instr, p_pc, p_valid}) begin
                    errors++; $display("FAIL rnd_hold cyc %0d: got %h %h %b expected %h %h %b", c, Instruction, pc_o, valid_o, p_instr, p_pc, p_valid);
                end
            end else if (valid_o === 1'b1) begin
                checks++;
                if (pc_o !== exp_pc || Instruction !== (exp_pc | 32'h1)) begin
                    errors++; $display("FAIL rnd_deliver cyc %0d: got pc %h instr %h expected pc %h", c, pc_o, Instruction, exp_pc);
                end
                exp_pc = pc_o + 32'h4;
                delivered++;
            end
            p_instr = Instruction; p_pc = pc_o; p_valid = valid_o;
        end
        stall_i = 1'b0; redirect_i = 1'b0;
        checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 200", delivered); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_combo();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
